// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared state encoding and counter width for the FIFO burst arbiter.
package arb_pkg;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ARB   = 3'd1;
  localparam state_t S_XFER  = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_HOLD  = 3'd4;
endpackage

// File: rtl/rr_fifo_arbiter_rr_pick.sv
// Combinational find-first over the request vector: starts just after ptr_i (wrapping),
// or at bit 0 when strict_i is set.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            strict_i,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_vld_o
);
  int   cand;
  logic found;

  always_comb begin
    gnt_id_o = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = strict_i ? i : (int'(ptr_i) + 1 + i) % N_CH;
      if (!found && req_i[cand[ID_W-1:0]]) begin
        found    = 1'b1;
        gnt_id_o = cand[ID_W-1:0];
      end
    end
    gnt_vld_o = found;
  end
endmodule

// File: rtl/rr_fifo_arbiter.sv
// Drains N_CH source FIFOs into one downstream FIFO in bursts of up to BURST words.
// Build option ARB_STRICT_PRIO_EN: lowest-index non-empty source wins instead of round-robin.
module rr_fifo_arbiter
  import arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 10,
  parameter int BURST  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     active_i,
  input  logic [N_CH-1:0]          src_empty_i,
  input  logic [N_CH*DATA_W-1:0]   src_data_i,
  input  logic                     dn_almost_full_i,
  output logic [N_CH-1:0]          src_pop_o,
  output logic                     dn_push_o,
  output logic [DATA_W-1:0]        dn_data_o,
  output logic [$clog2(N_CH)-1:0]  grant_id_o,
  output logic                     busy_o
);
  // States: IDLE wait for active | ARB pick source | XFER pop burst | DRAIN last push | HOLD downstream full
  localparam int ID_W = $clog2(N_CH);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, pick_id;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   pop_q, pop_d;
  logic              push_q;
  logic [DATA_W-1:0] data_q;
  logic              pick_vld, strict, pop_ok;

`ifdef ARB_STRICT_PRIO_EN
  assign strict = 1'b1;
`else
  assign strict = 1'b0;
`endif

  rr_pick #(.N_CH(N_CH), .ID_W(ID_W)) u_pick (
    .req_i     (~src_empty_i),
    .ptr_i     (ptr_q),
    .strict_i  (strict),
    .gnt_id_o  (pick_id),
    .gnt_vld_o (pick_vld)
  );

  assign pop_ok = active_i && !dn_almost_full_i && !src_empty_i[gnt_q] &&
                  (cnt_q < CNT_W'(BURST));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= ID_W'(N_CH - 1);
      cnt_q   <= '0;
      pop_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      // Source data is valid the cycle after the pop strobe, so push follows pop by one edge.
      push_q  <= |pop_q;
      if (|pop_q) data_q <= src_data_i[gnt_q*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pop_d   = '0;
    unique case (state_q)
      S_IDLE: if (active_i) state_d = S_ARB;
      S_ARB: begin
        if (!active_i) state_d = S_IDLE;
        else if (dn_almost_full_i) state_d = S_HOLD;
        else if (pick_vld) begin
          gnt_d   = pick_id;
          ptr_d   = pick_id;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (pop_ok) begin
          pop_d[gnt_q] = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dn_almost_full_i) state_d = S_HOLD;
        else if (!active_i) state_d = S_IDLE;
        else state_d = S_ARB;
      end
      S_HOLD: if (!dn_almost_full_i) state_d = active_i ? S_ARB : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == S_XFER) || (state_q == S_DRAIN);
    src_pop_o  = pop_q;
    dn_push_o  = push_q;
    dn_data_o  = data_q;
    grant_id_o = gnt_q;
  end
endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: queue-based source FIFOs, scoreboard on every push, directed corner cases.
module tb_rr_fifo_arbiter;
  localparam int N_CH = 4, DATA_W = 10, BURST = 4, ID_W = 2;

  logic clk = 1'b0, reset = 1'b0, active = 1'b0, af = 1'b0;
  logic [N_CH-1:0]        src_empty = '1;
  logic [N_CH*DATA_W-1:0] src_data = '0;
  logic [N_CH-1:0]        src_pop;
  logic                   dn_push;
  logic [DATA_W-1:0]      dn_data;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  always #5 clk = ~clk;

  rr_fifo_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk_i(clk), .reset_i(reset), .active_i(active), .src_empty_i(src_empty),
    .src_data_i(src_data), .dn_almost_full_i(af), .src_pop_o(src_pop),
    .dn_push_o(dn_push), .dn_data_o(dn_data), .grant_id_o(grant_id), .busy_o(busy)
  );

  int total = 0, bad = 0;
  logic [DATA_W-1:0] fq [N_CH][$];
  logic [DATA_W-1:0] pushed [$];
  int runs [$], grants [$];
  int pop_cnt = 0, run_len = 0, mptr = N_CH - 1;
  bit pend_v = 0, busy_prev = 0, rand_mode = 0;
  logic [DATA_W-1:0] pend_w = '0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < N_CH; c++) if (fq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference grant rule: first non-empty source after the last grant (or lowest index in strict build).
  function automatic int model_pick(input int p);
    for (int k = 1; k <= N_CH; k++) begin
      int c;
`ifdef ARB_STRICT_PRIO_EN
      c = k - 1;
`else
      c = (p + k) % N_CH;
`endif
      if (fq[c].size() != 0) return c;
    end
    return -1;
  endfunction

  function automatic int lowest(input logic [N_CH-1:0] m);
    for (int c = 0; c < N_CH; c++) if (m[c]) return c;
    return -1;
  endfunction

  // Source FIFO model and scoreboard; a pop strobe is serviced right after the edge that raised it.
  always @(posedge clk) begin
    logic rst_s, af_s, act_s;
    int ch, exp_g;
    logic [DATA_W-1:0] w;
    rst_s = reset; af_s = af; act_s = active;
    #1;
    if (!rst_s) begin
      check("reset_no_push", int'(dn_push), 0);
      pend_v = 0;
      mptr = N_CH - 1;
    end else if (pend_v) begin
      check("push_strobe", int'(dn_push), 1);
      check("push_data", int'(dn_data), int'(pend_w));
      pushed.push_back(dn_data);
      pend_v = 0;
    end else if (dn_push) begin
      check("spurious_push", int'(dn_push), 0);
    end

    if (rst_s && busy && !busy_prev) begin
      exp_g = model_pick(mptr);
      check("grant_choice", int'(grant_id), exp_g);
      grants.push_back(exp_g);
      mptr = exp_g;
    end
    busy_prev = busy;

    if (src_pop != '0) begin
      ch = mptr;
      check("pop_onehot", int'(src_pop), 1 << ch);
      check("pop_gate", int'({af_s, act_s}), 1);
      check("pop_nonempty", int'(fq[ch].size() > 0), 1);
      if (fq[ch].size() > 0) begin
        w = fq[ch].pop_front();
        src_data[ch*DATA_W +: DATA_W] = w;
        pend_w = w;
        pend_v = 1;
      end
      pop_cnt++;
      run_len++;
      check("burst_limit", int'(run_len <= BURST), 1);
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end

    if (rand_mode && all_empty())
      for (int c = 0; c < N_CH; c++) begin
        int n;
        n = $urandom_range(0, 6);
        repeat (n) fq[c].push_back(DATA_W'($urandom));
      end
    for (int c = 0; c < N_CH; c++) src_empty[c] = (fq[c].size() == 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic load(input int c, input int base, input int n);
    for (int i = 0; i < n; i++) fq[c].push_back(DATA_W'(base + i));
  endtask

  task automatic clear_logs();
    pushed.delete(); runs.delete(); grants.delete(); pop_cnt = 0;
  endtask

  task automatic wait_drained(input int maxc);
    bit done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      cyc(1);
      if (all_empty() && !busy && src_pop == '0 && !dn_push) done = 1;
    end
    check("drain_done", int'(done), 1);
    cyc(2);
  endtask

  task automatic wait_pops(input int n, input int maxc);
    for (int k = 0; k < maxc && pop_cnt < n; k++) cyc(1);
    check("wait_pops", int'(pop_cnt >= n), 1);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct packed {
    logic [N_CH-1:0] mask;
    logic [ID_W-1:0] exp_g;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int wbase, exp_g, got;
    // Single-word grant sequence from reset pointer 3; each entry's expectation follows from the previous drain.
    vecs[0] = '{4'b1111, 2'd0};
    vecs[1] = '{4'b0110, 2'd1};
    vecs[2] = '{4'b1001, 2'd3};
    vecs[3] = '{4'b0001, 2'd0};
    vecs[4] = '{4'b0101, 2'd2};
    vecs[5] = '{4'b1000, 2'd3};
    vecs[6] = '{4'b0100, 2'd2};
    vecs[7] = '{4'b1010, 2'd3};

    // Reset held with active and all sources loaded
    reset = 0; active = 1;
    for (int c = 0; c < N_CH; c++) load(c, 16 * c, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_src_pop", int'(src_pop), 0);
      check("rst_dn_push", int'(dn_push), 0);
      check("rst_grant", int'(grant_id), 0);
      check("rst_busy", int'(busy), 0);
    end
    for (int c = 0; c < N_CH; c++) fq[c].delete();
    cyc(2);
    active = 0; reset = 1;
    cyc(2);

    wbase = 600;
    foreach (vecs[i]) begin
      for (int c = 0; c < N_CH; c++) if (vecs[i].mask[c]) begin load(c, wbase, 1); wbase++; end
      cyc(2);
      active = 1;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin cyc(1); if (busy) got = 1; end
`ifdef ARB_STRICT_PRIO_EN
      exp_g = lowest(vecs[i].mask);
`else
      exp_g = int'(vecs[i].exp_g);
`endif
      check("vec_busy", got, 1);
      check("vec_grant", int'(grant_id), exp_g);
      wait_drained(100);
      active = 0;
      cyc(2);
    end

    // Six words on ch0 split 4 + 2
    clear_logs();
    load(0, 100, 6);
    cyc(2); active = 1;
    wait_drained(100); active = 0; cyc(2);
    check("t2_pushes", pushed.size(), 6);
    for (int i = 0; i < pushed.size(); i++) check("t2_order", int'(pushed[i]), 100 + i);
    check("t2_runs", runs.size(), 2);
    check("t2_run0", at(runs, 0), 4);
    check("t2_run1", at(runs, 1), 2);

    // ch1 and ch3, then ch0/ch1 to show the 3 -> 0 wrap
    clear_logs();
    load(1, 200, 2); load(3, 210, 2);
    cyc(2); active = 1;
    wait_drained(100);
    load(0, 220, 1); load(1, 221, 1);
    wait_drained(100); active = 0; cyc(2);
    check("t3_g0", at(grants, 0), 1);
    check("t3_g1", at(grants, 1), 3);
    check("t3_g2", at(grants, 2), 0);
    check("t3_g3", at(grants, 3), 1);
    check("t3_run0", at(runs, 0), 2);
    check("t3_run1", at(runs, 1), 2);
    check("t3_pushes", pushed.size(), 6);
    check("t3_last", pushed.size() == 6 ? int'(pushed[5]) : -1, 221);

    // almost_full after the 2nd pop of a burst
    clear_logs();
    load(2, 300, 6); load(3, 310, 2);
    cyc(2); active = 1;
    wait_pops(2, 30);
    af = 1;
    cyc(5);
    check("t4_pops_held", pop_cnt, 2);
    check("t4_pushes_held", pushed.size(), 2);
    check("t4_hold_busy", int'(busy), 0);
    check("t4_hold_grant", int'(grant_id), 2);
    af = 0;
    wait_drained(100); active = 0; cyc(2);
    check("t4_pushes", pushed.size(), 8);
    check("t4_g0", at(grants, 0), 2);
`ifdef ARB_STRICT_PRIO_EN
    check("t4_g1", at(grants, 1), 2);
    check("t4_run1", at(runs, 1), 4);
`else
    check("t4_g1", at(grants, 1), 3);
    check("t4_run1", at(runs, 1), 2);
`endif
    check("t4_run0", at(runs, 0), 2);

    // active drops mid-burst
    clear_logs();
    load(0, 400, 4);
    cyc(2); active = 1;
    wait_pops(2, 30);
    active = 0;
    cyc(1);
    check("t5_push_lands", pushed.size(), 2);
    cyc(1);
    check("t5_idle_busy", int'(busy), 0);
    check("t5_pops", pop_cnt, 2);
    active = 1;
    wait_drained(100); active = 0; cyc(2);
    check("t5_pushes", pushed.size(), 4);
    check("t5_word2", pushed.size() > 2 ? int'(pushed[2]) : -1, 402);

    // reset during XFER discards the in-flight word
    clear_logs();
    load(1, 500, 4);
    cyc(2); active = 1;
    wait_pops(1, 30);
    reset = 0;
    cyc(1);
    check("t6_src_pop", int'(src_pop), 0);
    check("t6_dn_push", int'(dn_push), 0);
    check("t6_dn_data", int'(dn_data), 0);
    check("t6_grant", int'(grant_id), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_no_push", pushed.size(), 0);
    reset = 1;
    wait_drained(100); active = 0; cyc(2);
    check("t6_pushes", pushed.size(), 3);
    check("t6_first", pushed.size() > 0 ? int'(pushed[0]) : -1, 501);

    // Randomized traffic against the scoreboard
    clear_logs();
    rand_mode = 1;
    active = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      af     = ($urandom_range(0, 9) < 3);
      active = ($urandom_range(0, 39) != 0);
    end
    rand_mode = 0; af = 0; active = 1;
    wait_drained(400);
    active = 0;
    cyc(3);
    check("rand_all_pushed", int'(pend_v), 0);
    check("rand_traffic", int'(pushed.size() > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
